fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS CPU: owns the program counter, drives the word address into the instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It resolves next-PC from sequential flow, taken `beq`/`bne`, and `j` redirects signalled by decode. It supports pipeline stall and wrong-path squash, and keeps a fetched-instruction counter. It sits directly upstream of the instruction ROM and of decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `Clk`  in  1  rising-edge clock.
- `Clrn`  in  1  synchronous, active-low reset.
- `Stall`  in  1  hold PC and IF/ID contents (hazard from decode).
- `BranchTaken`  in  1  instruction in IF/ID is a branch and its condition holds.
- `Jump`  in  1  instruction in IF/ID is `j`.
- `Imm16`  in  16  branch offset field of IF/ID instruction (words, signed).
- `JIdx26`  in  26  jump index field of IF/ID instruction.
- `Inst`  in  32  instruction word returned combinationally by the ROM for `Addr`.
- `Addr`  out  32  current PC, presented to the ROM.
- `IfId_Inst`  out  32  registered instruction.
- `IfId_Pc4`  out  32  registered PC+4 of that instruction.
- `IfId_Valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `FetchCount`  out  32  number of valid instructions loaded into IF/ID.

## Operation
- `Addr` = PC register, combinational; ROM returns `Inst` in the same cycle.
- Redirect request `Redir` = (`Jump` | `BranchTaken`) & `IfId_Valid`; requests with `IfId_Valid`=0 are ignored.
- Targets (computed from IF/ID contents, 32-bit, wrap modulo 2^32):
  - branch: `IfId_Pc4` + (sign-extend(`Imm16`) << 2).
  - jump: {`IfId_Pc4`[31:28], `JIdx26`, 2'b00}.
  - `Jump` has priority over `BranchTaken` when both assert.
- Per rising edge, in priority order:
  1. `Clrn`=0: PC <= `RESET_PC`; `IfId_Inst` <= 0; `IfId_Pc4` <= 0; `IfId_Valid` <= 0; `FetchCount` <= 0.
  2. `Stall`=1: PC, IF/ID, and `FetchCount` all hold. Redirect is not taken; decode keeps asserting it until `Stall` drops.
  3. `Redir`=1: PC <= target. The instruction fetched this cycle is wrong-path: IF/ID loads {`Inst`, PC+4} with `IfId_Valid` <= 0 (see Configuration).
  4. otherwise: PC <= PC+4; IF/ID <= {`Inst`, PC+4}; `IfId_Valid` <= 1.
- `FetchCount` increments by 1 exactly on edges where `IfId_Valid` is loaded with 1, and wraps at 2^32.
- PC+4 wraps from 32'hFFFF_FFFC to 0. Addresses beyond ROM depth are not checked here.

## Timing
- Reset values: `Addr`=`RESET_PC`, `IfId_Inst`=0, `IfId_Pc4`=0, `IfId_Valid`=0, `FetchCount`=0.
- Fetch latency: one cycle from `Addr` to `IfId_Inst`. Throughput is one instruction per cycle when not stalled.
- Redirect penalty: one bubble without delay slot; zero with it.
- Reset asserted mid-stall or mid-redirect overrides both on that edge.
- `Stall` asserted in the same cycle as `Redir`: stall wins and the redirect is re-evaluated next cycle.

## Configuration
- `FETCH_DELAY_SLOT_EN` defined: MIPS branch delay slot. On a redirect edge the fetched instruction is kept with `IfId_Valid` <= 1 and `FetchCount` increments.
- Not defined: the fetched instruction is squashed (`IfId_Valid` <= 0, no count), as described in Operation.

## Test plan
- Reset: hold `Clrn`=0 for 2 cycles, then release -> `Addr`=0, `IfId_Valid`=0. The next edges give `Addr` 4, 8, with `IfId_Pc4` 4, 8 and `FetchCount` 1, 2.
- Forward branch: `IfId_Pc4`=32'h2C, `Imm16`=16'h0002, `BranchTaken`=1 -> next `Addr`=32'h34. Without the macro, `IfId_Valid`=0 that cycle; with the macro, `IfId_Valid`=1.
- Backward branch: `IfId_Pc4`=32'h2C, `Imm16`=16'hFFFE -> next `Addr`=32'h24.
- Jump priority: `IfId_Pc4`=32'h3C, `JIdx26`=26'h10, `Jump`=1 and `BranchTaken`=1 -> next `Addr`=32'h40.
- Stall: `Stall`=1 for 3 cycles at `Addr`=32'h10 with `BranchTaken`=1 -> `Addr`, IF/ID, and `FetchCount` are unchanged for all 3 cycles. The redirect takes effect on the first edge after `Stall` drops.
- Mid-run reset: `Clrn`=0 for one edge at `Addr`=32'h20 with `FetchCount`=8 -> `Addr`=0, `FetchCount`=0, `IfId_Valid`=0; also check `Redir` is ignored while `IfId_Valid`=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Purpose     : MIPS instruction-fetch stage. Owns the PC, addresses the instruction ROM and
//               captures the returned word into the IF/ID pipeline register.
// Latency     : 1 cycle from Addr to IfId_Inst; redirect costs one bubble (zero with delay slot).
// Backpressure: Stall freezes the PC, IF/ID and FetchCount; a pending redirect waits until Stall drops.
//
// Optional feature macro: FETCH_DELAY_SLOT_EN
//    defined     -> MIPS branch delay slot: the word fetched on a redirect edge is kept as valid.
//    not defined -> that word is squashed (IfId_Valid = 0, not counted).
//
// Ports
//    Clk, Clrn          rising-edge clock, synchronous active-low reset
//    Stall              hold PC, IF/ID and FetchCount (hazard from decode)
//    BranchTaken, Jump  redirect requests for the instruction currently in IF/ID
//    Imm16, JIdx26      branch offset (words, signed) / jump index of the IF/ID instruction
//    Inst               instruction word returned combinationally by the ROM for Addr
//    Addr               current PC, presented to the ROM
//    IfId_Inst/Pc4/Valid  IF/ID pipeline register (Valid = 0 marks a bubble)
//    FetchCount         number of valid instructions loaded into IF/ID, wraps at 2^32
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Clrn,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic        Jump,
   input  logic [15:0] Imm16,
   input  logic [25:0] JIdx26,
   input  logic [31:0] Inst,
   output logic [31:0] Addr,
   output logic [31:0] IfId_Inst,
   output logic [31:0] IfId_Pc4,
   output logic        IfId_Valid,
   output logic [31:0] FetchCount
);

`ifdef FETCH_DELAY_SLOT_EN
   localparam logic KEEP_SLOT = 1'b1;
`else
   localparam logic KEEP_SLOT = 1'b0;
`endif

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] redir_target;
   logic [31:0] next_pc;
   logic        redir;
   logic        load_valid;

   assign Addr = pc;

   // Wraps naturally from 32'hFFFF_FFFC to 0.
   assign pc_plus4 = pc + 32'd4;

   // Requests against a bubble in IF/ID are meaningless and must be ignored.
   assign redir = (Jump | BranchTaken) & IfId_Valid;

   // Targets are relative to the instruction sitting in IF/ID, not to the current PC.
   assign br_offset    = {{14{Imm16[15]}}, Imm16, 2'b00};
   assign br_target    = IfId_Pc4 + br_offset;
   assign j_target     = {IfId_Pc4[31:28], JIdx26, 2'b00};
   assign redir_target = Jump ? j_target : br_target;

   assign next_pc = redir ? redir_target : pc_plus4;

   // The word fetched on a redirect edge is the sequential successor of the branch:
   // it is the delay slot when that feature is built in, otherwise wrong-path.
   assign load_valid = redir ? KEEP_SLOT : 1'b1;

   always_ff @(posedge Clk) begin
      if (!Clrn) begin
         pc         <= RESET_PC;
         IfId_Inst  <= 32'd0;
         IfId_Pc4   <= 32'd0;
         IfId_Valid <= 1'b0;
         FetchCount <= 32'd0;
      end else if (!Stall) begin
         pc         <= next_pc;
         IfId_Inst  <= Inst;
         IfId_Pc4   <= pc_plus4;
         IfId_Valid <= load_valid;
         if (load_valid) begin
            FetchCount <= FetchCount + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Each step drives one cycle of inputs and queues the
// hand-computed register state expected after that edge; a separate monitor pops and
// compares on the following falling edge.
module tb_fetch_stage;

`ifdef FETCH_DELAY_SLOT_EN
   localparam int DS = 1;
`else
   localparam int DS = 0;
`endif

   logic        Clk;
   logic        Clrn;
   logic        Stall;
   logic        BranchTaken;
   logic        Jump;
   logic [15:0] Imm16;
   logic [25:0] JIdx26;
   logic [31:0] Inst;
   logic [31:0] Addr;
   logic [31:0] IfId_Inst;
   logic [31:0] IfId_Pc4;
   logic        IfId_Valid;
   logic [31:0] FetchCount;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .Clk        (Clk),
      .Clrn       (Clrn),
      .Stall      (Stall),
      .BranchTaken(BranchTaken),
      .Jump       (Jump),
      .Imm16      (Imm16),
      .JIdx26     (JIdx26),
      .Inst       (Inst),
      .Addr       (Addr),
      .IfId_Inst  (IfId_Inst),
      .IfId_Pc4   (IfId_Pc4),
      .IfId_Valid (IfId_Valid),
      .FetchCount (FetchCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ROM model: a distinct, address-derived word for every location.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
   endfunction

   assign Inst = rom(Addr);

   function automatic logic dsv();
      return (DS != 0);
   endfunction

   task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, got, exp);
      end
   endtask

   // Monitor: one queued expectation per rising edge, compared mid-cycle.
   always @(negedge Clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cmp(e.name, "addr",  Addr,       e.addr);
         cmp(e.name, "inst",  IfId_Inst,  e.inst);
         cmp(e.name, "pc4",   IfId_Pc4,   e.pc4);
         cmp(e.name, "valid", {31'd0, IfId_Valid}, {31'd0, e.valid});
         cmp(e.name, "count", FetchCount, e.cnt);
      end
   end

   task automatic step(input logic clrn, input logic stall, input logic bt, input logic jmp,
                       input logic [15:0] imm, input logic [25:0] jidx, input string nm,
                       input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                       input logic ev, input logic [31:0] ec);
      exp_t e;
      Clrn        = clrn;
      Stall       = stall;
      BranchTaken = bt;
      Jump        = jmp;
      Imm16       = imm;
      JIdx26      = jidx;
      @(posedge Clk);
      #1;
      e.name  = nm;
      e.addr  = ea;
      e.inst  = ei;
      e.pc4   = ep;
      e.valid = ev;
      e.cnt   = ec;
      sb.push_back(e);
   endtask

   // Plain sequential fetch with no control inputs asserted.
   task automatic seq(input string nm, input logic [31:0] ea, input logic [31:0] ec);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, nm, ea, rom(ea - 32'd4), ea, 1'b1, ec);
   endtask

   initial begin
      Clrn = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
      Imm16 = 16'h0; JIdx26 = 26'h0;

      // Reset held for two edges.
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, "reset0", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, "reset1", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

      // Sequential fetch up to Addr = IfId_Pc4 = 0x2C.
      for (int n = 1; n <= 11; n++) seq("seq", 32'(4 * n), 32'(n));

      // Forward branch: 0x2C + (2 << 2) = 0x34.
      step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 26'h0, "fwd_br",
           32'h34, rom(32'h2C), 32'h30, dsv(), 32'(11 + DS));
      seq("after_fwd", 32'h38, 32'(12 + DS));

      // Jump to 0x28 (index 0xA) to set up the backward branch.
      step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 26'h00A, "jump28",
           32'h28, rom(32'h38), 32'h3C, dsv(), 32'(12 + 2 * DS));
      seq("at2c", 32'h2C, 32'(13 + 2 * DS));

      // Backward branch: 0x2C - 8 = 0x24.
      step(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0, "bwd_br",
           32'h24, rom(32'h2C), 32'h30, dsv(), 32'(13 + 3 * DS));
      seq("after_bwd", 32'h28, 32'(14 + 3 * DS));
      seq("s2c", 32'h2C, 32'(15 + 3 * DS));
      seq("s30", 32'h30, 32'(16 + 3 * DS));
      seq("s34", 32'h34, 32'(17 + 3 * DS));
      seq("s38", 32'h38, 32'(18 + 3 * DS));
      seq("s3c", 32'h3C, 32'(19 + 3 * DS));

      // Jump wins over branch: jump -> 0x40, branch would give 0x44.
      step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 26'h010, "jmp_prio",
           32'h40, rom(32'h3C), 32'h40, dsv(), 32'(19 + 4 * DS));
      seq("after_prio", 32'h44, 32'(20 + 4 * DS));

      // Jump to 0x0C, then one sequential step so Addr = IfId_Pc4 = 0x10, valid.
      step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 26'h003, "jump0c",
           32'h0C, rom(32'h44), 32'h48, dsv(), 32'(20 + 5 * DS));
      seq("at10", 32'h10, 32'(21 + 5 * DS));

      // Stall with a pending branch (target 0x10 + 16 = 0x20): nothing moves for 3 edges.
      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0004, 26'h0, "stall",
              32'h10, rom(32'h0C), 32'h10, 1'b1, 32'(21 + 5 * DS));
      step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 26'h0, "unstall_br",
           32'h20, rom(32'h10), 32'h14, dsv(), 32'(21 + 6 * DS));

      // Reset overrides a simultaneous stall and redirect.
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 26'h0, "rst_ovr", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      for (int n = 1; n <= 8; n++) seq("reseq", 32'(4 * n), 32'(n));

      // Mid-run reset at Addr 0x20, FetchCount 8.
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 26'h0, "midrst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

      // Redirect requested while IfId_Valid = 0 must be ignored.
      step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 26'h020, "redir_ign",
           32'h4, rom(32'h0), 32'h4, 1'b1, 32'd1);
      seq("post", 32'h8, 32'd2);

      repeat (3) @(negedge Clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
